// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: sequences one external 4-bit adder slice to add two
// WIDTH-bit operands nibble-serially, LSB nibble first. The requester uses a
// start/busy/done handshake. S and cout are held until the next add completes.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16  // multiple of 4, >= 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic [3:0]       add_x,
  output logic [3:0]       add_y,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NIB - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and slice/handshake outputs.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    add_x   = 4'h0;
    add_y   = 4'h0;
    add_cin = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = A;
          opb_d   = B;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        busy    = 1'b1;
        add_x   = opa_q[3:0];
        add_y   = opb_q[3:0];
        add_cin = carry_q;
        // Each slice result enters at the top so the LSB nibble ends up at bit 0.
        sum_d   = {add_s, sum_q[WIDTH-1:4]};
        carry_d = add_cout;
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // Visible result only changes here, so S is stable through the next RUN.
          s_d     = sum_d;
          cout_d  = add_cout;
          cnt_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        done = 1'b1;
        if (start) begin
          opa_d   = A;
          opb_d   = B;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign S    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed checks of the nibble-serial add sequencer
// with the external slice modelled as a 4-bit full adder.
module tb_nibble_serial_add_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic [3:0]       add_x;
  logic [3:0]       add_y;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;

  int checks;
  int errors;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cin      (cin),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .cout     (cout),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // 4-bit ripple slice
  always_comb {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one add, scramble the inputs after the start edge, and follow the
  // RUN phase until done (bounded). Reports observations only.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input bit disturb,
                        output int lat, output logic [3:0] x0, output logic [3:0] y0,
                        output logic [WIDTH-1:0] s_run, output bit cin_all,
                        output bit busy_all);
    @(posedge clk); #1;
    A = a; B = b; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; cin = ~c;
    lat = 0; cin_all = 1'b1; busy_all = 1'b1; x0 = 4'hx; y0 = 4'hx; s_run = 'x;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (lat == 0) begin
        x0 = add_x; y0 = add_y; s_run = S;
      end
      if (busy !== 1'b1) busy_all = 1'b0;
      if (add_cin !== 1'b1) cin_all = 1'b0;
      if (lat > 20) break;
      if (disturb && lat == 1) begin
        start = 1'b1; A = 16'h0F0F; B = 16'h7070; cin = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cin = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL reset_S got %h exp 0000", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b exp 0", cout); end
    checks++; if (add_x !== 4'h0 || add_y !== 4'h0 || add_cin !== 1'b0) begin
      errors++; $display("FAIL reset_slice got x=%h y=%h c=%b exp 0 0 0", add_x, add_y, add_cin);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [3:0] x0, y0; logic [WIDTH-1:0] s_run; bit ca, ba;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, x0, y0, s_run, ca, ba);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
    checks++; if (x0 !== 4'h4 || y0 !== 4'h1) begin
      errors++; $display("FAIL basic_first_nibble got x=%h y=%h exp 4 1", x0, y0);
    end
    checks++; if (S !== 16'h2345) begin errors++; $display("FAIL basic_S got %h exp 2345", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got %b exp 0", cout); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    checks++; if (busy !== 1'b0 || S !== 16'h2345) begin
      errors++; $display("FAIL basic_idle_hold got busy=%b S=%h exp 0 2345", busy, S);
    end
  endtask

  task automatic test_ripple();
    int lat; logic [3:0] x0, y0; logic [WIDTH-1:0] s_run; bit ca, ba;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, x0, y0, s_run, ca, ba);
    checks++; if (s_run !== 16'h2345) begin
      errors++; $display("FAIL ripple_S_held_in_run got %h exp 2345", s_run);
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL ripple_latency got %0d exp 4", lat); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL ripple_S got %h exp 0000", S); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got %b exp 1", cout); end
  endtask

  task automatic test_all_ones();
    int lat; logic [3:0] x0, y0; logic [WIDTH-1:0] s_run; bit ca, ba;
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, lat, x0, y0, s_run, ca, ba);
    checks++; if (ca !== 1'b1) begin errors++; $display("FAIL ones_add_cin got %b exp 1", ca); end
    checks++; if (S !== 16'hFFFF) begin errors++; $display("FAIL ones_S got %h exp ffff", S); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ones_cout got %b exp 1", cout); end
  endtask

  task automatic test_start_while_busy();
    int lat; logic [3:0] x0, y0; logic [WIDTH-1:0] s_run; bit ca, ba;
    run_op(16'h0123, 16'h4567, 1'b1, 1'b1, lat, x0, y0, s_run, ca, ba);
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_held got %b exp 1", ba); end
    checks++; if (lat != 4) begin errors++; $display("FAIL busy_latency got %0d exp 4", lat); end
    checks++; if (S !== 16'h468B) begin errors++; $display("FAIL busy_S got %h exp 468b", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL busy_cout got %b exp 0", cout); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_not_queued got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    @(posedge clk); #1;
    A = 16'h2222; B = 16'h3333; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;  // start edge
    start = 1'b0;
    @(posedge clk); #1;  // RUN cycle 2 begins
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
    checks++; if (S !== 16'h0000) begin errors++; $display("FAIL midrst_S got %h exp 0000", S); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b exp 0", cout); end
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrst_no_done got 1 exp 0"); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a [3];
    logic [WIDTH-1:0] b [3];
    logic             c [3];
    logic [WIDTH:0]   exp_sum;
    int lat;
    for (int k = 0; k < 3; k++) begin
      a[k] = WIDTH'($urandom); b[k] = WIDTH'($urandom); c[k] = 1'($urandom);
    end
    @(posedge clk); #1;
    A = a[0]; B = b[0]; cin = c[0]; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;  // accept edge for op k
      if (k < 2) begin
        A = a[k+1]; B = b[k+1]; cin = c[k+1];
      end else begin
        start = 1'b0;
      end
      lat = 0;
      forever begin
        @(negedge clk);
        if (done === 1'b1 || lat > 20) break;
        @(posedge clk); #1;
        lat++;
      end
      exp_sum = {1'b0, a[k]} + {1'b0, b[k]} + {{WIDTH{1'b0}}, c[k]};
      checks++; if (lat != 4) begin
        errors++; $display("FAIL b2b_latency op%0d got %0d exp 4", k, lat);
      end
      checks++; if (S !== exp_sum[WIDTH-1:0]) begin
        errors++; $display("FAIL b2b_S op%0d got %h exp %h", k, S, exp_sum[WIDTH-1:0]);
      end
      checks++; if (cout !== exp_sum[WIDTH]) begin
        errors++; $display("FAIL b2b_cout op%0d got %b exp %b", k, cout, exp_sum[WIDTH]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_all_ones();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
